// File: rtl/fifo_sync_if.sv
// Handshake/data bundle between a stream producer/consumer and fifo_sync.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface fifo_sync_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO on a flop array: occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_sync #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_TH  = (2 ** ADDR_W) - 2,
  parameter int unsigned AEMPTY_TH = 1
) (
  input logic        clk,
  input logic        nRST,
  fifo_sync_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] DepthLvl  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PtrOne    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AfullLvl  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AemptyLvl = (ADDR_W + 1)'(AEMPTY_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;
  logic              r_underflow;

  logic [ADDR_W:0] w_level;
  logic            w_empty;
  logic            w_full;
  logic            w_rd_acc;
  logic            w_wr_acc;

  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == DepthLvl);
  assign w_rd_acc = bus.rd_en & ~w_empty;
  // A read in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
        r_wr_ptr                    <= r_wr_ptr + PtrOne;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      if (bus.wr_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.rd_data      = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.level        = w_level;
  assign bus.almost_empty = (w_level <= AemptyLvl);
  assign bus.almost_full  = (w_level >= AfullLvl);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: expected read data queued at issue time and checked
// by an independent monitor whenever a read is accepted.
module tb_fifo_sync;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;

  logic clk;
  logic nRST;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_q[$];

  fifo_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fifo_sync #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AFULL_TH (14),
    .AEMPTY_TH(1)
  ) dut (
    .clk (clk),
    .nRST(nRST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: sample on the falling edge, i.e. the data presented for the coming edge.
  always @(negedge clk) begin
    if (nRST && !bus.clr && bus.rd_en && !bus.empty) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", bus.rd_data, 32'hdead_beef);
      end else begin
        chk("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic c, input logic w, input logic [31:0] d, input logic r);
    bus.clr     = c;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    #1;
    bus.clr   = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    exp_q.push_back(d);
    cyc(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    nRST        = 1'b0;
    bus.clr     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    #23;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_udf", 32'(bus.underflow), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1;
    nRST = 1'b1;

    // Basic three-word write then read.
    wr(32'h11);
    chk("lvl_w1", 32'(bus.level), 32'd1);
    chk("aempty_l1", 32'(bus.almost_empty), 32'd1);
    chk("head_w1", bus.rd_data, 32'h11);
    wr(32'h22);
    chk("lvl_w2", 32'(bus.level), 32'd2);
    chk("aempty_l2", 32'(bus.almost_empty), 32'd0);
    wr(32'h33);
    chk("lvl_w3", 32'(bus.level), 32'd3);
    rd();
    chk("lvl_r1", 32'(bus.level), 32'd2);
    rd();
    chk("lvl_r2", 32'(bus.level), 32'd1);
    rd();
    chk("lvl_r3", 32'(bus.level), 32'd0);
    chk("empty_r3", 32'(bus.empty), 32'd1);
    chk("ovf_basic", 32'(bus.overflow), 32'd0);
    chk("udf_basic", 32'(bus.underflow), 32'd0);

    // Fill to full, then a dropped write.
    for (int i = 0; i < 16; i++) begin
      wr(32'(i));
      if (i == 12) chk("afull_l13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("afull_l14", 32'(bus.almost_full), 32'd1);
    end
    chk("full_16", 32'(bus.full), 32'd1);
    chk("lvl_16", 32'(bus.level), 32'd16);
    cyc(1'b0, 1'b1, 32'hAA, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("lvl_after_drop", 32'(bus.level), 32'd16);
    for (int i = 0; i < 16; i++) rd();
    chk("empty_drain", 32'(bus.empty), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full with simultaneous read and write.
    for (int i = 0; i < 16; i++) wr(32'(i));
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'h55);
      cyc(1'b0, 1'b1, 32'h55, 1'b1);
      chk("rw_full_lvl", 32'(bus.level), 32'd16);
      chk("rw_full_full", 32'(bus.full), 32'd1);
      chk("rw_full_ovf", 32'(bus.overflow), 32'd0);
    end
    for (int i = 0; i < 16; i++) rd();
    chk("empty_55", 32'(bus.empty), 32'd1);

    // Empty with simultaneous read and write.
    exp_q.push_back(32'h77);
    cyc(1'b0, 1'b1, 32'h77, 1'b1);
    chk("udf_set", 32'(bus.underflow), 32'd1);
    chk("lvl_e_rw", 32'(bus.level), 32'd1);
    chk("head_77", bus.rd_data, 32'h77);
    chk("empty_e_rw", 32'(bus.empty), 32'd0);
    rd();
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("udf_clr", 32'(bus.underflow), 32'd0);

    // Pointer wrap: 40 words with level bouncing 0..3.
    for (int b = 0; b < 13; b++) begin
      for (int k = 0; k < 3; k++) begin
        wr(32'h300 + 32'(b * 3 + k));
        chk("wrap_lvl_up", 32'(bus.level), 32'(k + 1));
      end
      for (int k = 0; k < 3; k++) begin
        rd();
        chk("wrap_lvl_dn", 32'(bus.level), 32'(2 - k));
      end
    end
    wr(32'h300 + 32'd39);
    rd();
    chk("wrap_empty", 32'(bus.empty), 32'd1);

    // Flush at level 5 with overflow pending; write during clr must be ignored.
    for (int i = 0; i < 16; i++) wr(32'h200 + 32'(i));
    cyc(1'b0, 1'b1, 32'hBB, 1'b0);
    for (int i = 0; i < 11; i++) rd();
    chk("pre_clr_lvl", 32'(bus.level), 32'd5);
    chk("pre_clr_ovf", 32'(bus.overflow), 32'd1);
    exp_q.delete();
    cyc(1'b1, 1'b1, 32'hEE, 1'b0);
    chk("clr_lvl", 32'(bus.level), 32'd0);
    chk("clr_empty", 32'(bus.empty), 32'd1);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    wr(32'h99);
    chk("post_clr_lvl", 32'(bus.level), 32'd1);
    rd();

    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
